uart_rx: RTL and testbench

Serial receiver paired with the team's `uart_tx`. It deserialises frames into bytes and presents each byte on a valid/ready output handshake.
- Frame format: idle-high line, start bit 0, 8 data bits MSB first, stop bit 1.
- With CLKS_PER_BIT=1 it accepts back-to-back frames at one bit per clock, i.e. a new start bit in the cycle right after a stop bit.
- It also detects false starts, framing errors and output overrun.

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_bit_timer.sv | 36 +++
 rtl/uart_rx.sv | 152 +++++++++++++++
 tb/tb_uart_rx.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encoding and line levels.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam int   DATA_BITS   = 8;
  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL  = 1'b1;

endpackage

// File: rtl/uart_bit_timer.sv
// Down-counting bit timer: tick is high while the count sits at zero.
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    load_i,
  input  logic [((CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1)-1:0] load_val_i,
  output logic                    tick_o
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // A load wins over counting; the counter parks at zero until reloaded.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = (cnt_q == '0);

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start/8 data bits MSB first/stop, byte out on a valid/ready handshake.
// Handshake: data is held stable while valid=1; a byte transfers on any cycle with valid&&ready.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ready,
  output logic       frame_err,
  output logic       overrun,
  output state_t     dbg_state
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int HALF  = (CLKS_PER_BIT - 1) / 2;
  localparam logic [CNT_W-1:0] RELOAD    = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'((HALF > 0) ? HALF - 1 : 0);
  localparam logic [2:0]       LAST_BIT  = 3'(DATA_BITS - 1);

  state_t     state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] data_q, data_d;
  logic       valid_q, valid_d;
  logic       frame_err_q, frame_err_d;
  logic       overrun_q, overrun_d;

  logic             tick;
  logic             load;
  logic [CNT_W-1:0] load_val;
  logic             byte_done;
  logic             stop_bad;

  uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .clk_i      (CLK),
    .rst_i      (RESET),
    .load_i     (load),
    .load_val_i (load_val),
    .tick_o     (tick)
  );

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    load      = 1'b0;
    load_val  = RELOAD;
    byte_done = 1'b0;
    stop_bad  = 1'b0;
    unique case (state_q)
      IDLE: begin
        // With no room for a mid-start check, the falling edge itself commits to a frame.
        if (rx == START_LEVEL) begin
          load = 1'b1;
          if (HALF == 0) begin
            state_d   = DATA;
            load_val  = RELOAD;
            bit_cnt_d = LAST_BIT;
          end else begin
            state_d  = START;
            load_val = HALF_LOAD;
          end
        end
      end
      START: begin
        if (tick) begin
          if (rx == START_LEVEL) begin
            state_d   = DATA;
            load      = 1'b1;
            load_val  = RELOAD;
            bit_cnt_d = LAST_BIT;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DATA: begin
        if (tick) begin
          shift_d  = {shift_q[6:0], rx};
          load     = 1'b1;
          load_val = RELOAD;
          if (bit_cnt_q == 3'd0) begin
            state_d = STOP;
          end else begin
            bit_cnt_d = bit_cnt_q - 3'd1;
          end
        end
      end
      STOP: begin
        // Leave at mid-stop so the next start edge can be seen as early as possible.
        if (tick) begin
          state_d = IDLE;
          if (rx == STOP_LEVEL) begin
            byte_done = 1'b1;
          end else begin
            stop_bad = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    data_d      = data_q;
    valid_d     = valid_q;
    frame_err_d = stop_bad;
    overrun_d   = 1'b0;
    if (byte_done) begin
      if (!valid_q || ready) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (valid_q && ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= IDLE;
      bit_cnt_q   <= 3'd0;
      shift_q     <= 8'h00;
      data_q      <= 8'h00;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx at 1 and 4 clocks per bit: directed vectors plus random line traffic vs a frame-level model.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int MAXN = 2048;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       rx1, rx4, rdy1, rdy4;
  logic [7:0] d1, d4;
  logic       v1, v4, fe1, fe4, ov1, ov4;
  state_t     st1, st4;

  uart_rx #(.CLKS_PER_BIT(1)) dut1 (
    .CLK(clk), .RESET(rst), .rx(rx1), .data(d1), .valid(v1), .ready(rdy1),
    .frame_err(fe1), .overrun(ov1), .dbg_state(st1)
  );

  uart_rx #(.CLKS_PER_BIT(4)) dut4 (
    .CLK(clk), .RESET(rst), .rx(rx4), .data(d4), .valid(v4), .ready(rdy4),
    .frame_err(fe4), .overrun(ov4), .dbg_state(st4)
  );

  typedef struct packed {
    logic       v;
    logic [7:0] d;
    logic       fe;
    logic       ov;
  } obs_t;

  // Per-cycle stimulus and observations; cycle k = the cycle after the k-th edge of a sequence.
  logic   line1[MAXN], line4[MAXN], rdya1[MAXN], rdya4[MAXN], rsta[MAXN];
  obs_t   ob1[MAXN], ob4[MAXN];
  state_t sob1[MAXN], sob4[MAXN];

  // Reference model data
  int         ev_kind[MAXN];   // 0 none, 1 good byte, 2 bad stop bit
  logic [7:0] ev_byte[MAXN];
  obs_t       ex[MAXN];

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string name, input int cyc, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic lv(input int which, input int i);
    return (which == 1) ? line1[i] : line4[i];
  endfunction

  function automatic logic rv(input int which, input int i);
    return (which == 1) ? rdya1[i] : rdya4[i];
  endfunction

  // ---------------- driver tasks ----------------
  task automatic clear_seq();
    for (int i = 0; i < MAXN; i++) begin
      line1[i] = 1'b1; line4[i] = 1'b1;
      rdya1[i] = 1'b1; rdya4[i] = 1'b1;
      rsta[i]  = 1'b0;
    end
  endtask

  task automatic set_line(input int which, input int idx, input logic val);
    if (which == 1) line1[idx] = val;
    else            line4[idx] = val;
  endtask

  // Writes one frame; glitch corrupts every data-bit cycle except the mid-bit sample point.
  task automatic put_frame(input int which, input int s, input logic [7:0] b, input logic stop, input bit glitch);
    int   c, h;
    logic bv;
    c = (which == 1) ? 1 : 4;
    h = (c - 1) / 2;
    for (int i = 0; i < 10; i++) begin
      if (i == 0)      bv = 1'b0;
      else if (i == 9) bv = stop;
      else             bv = b[8-i];
      for (int j = 0; j < c; j++) begin
        if (glitch && i >= 1 && i <= 8 && j != h) set_line(which, s + i*c + j, ~bv);
        else                                      set_line(which, s + i*c + j, bv);
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; rx1 = 1'b1; rx4 = 1'b1; rdy1 = 1'b1; rdy4 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset1", 0, {19'd0, v1, d1, fe1, ov1, st1}, {19'd0, 1'b0, 8'h00, 1'b0, 1'b0, IDLE});
    chk("reset4", 0, {19'd0, v4, d4, fe4, ov4, st4}, {19'd0, 1'b0, 8'h00, 1'b0, 1'b0, IDLE});
    @(posedge clk);
    #1;
  endtask

  task automatic run_seq(input int n);
    for (int k = 0; k < n; k++) begin
      rx1 = line1[k]; rx4 = line4[k]; rdy1 = rdya1[k]; rdy4 = rdya4[k]; rst = rsta[k];
      @(negedge clk);
      ob1[k] = {v1, d1, fe1, ov1}; sob1[k] = st1;
      ob4[k] = {v4, d4, fe4, ov4}; sob4[k] = st4;
      @(posedge clk);
      #1;
    end
    rst = 1'b0; rx1 = 1'b1; rx4 = 1'b1;
  endtask

  // ---------------- reference model ----------------
  // Frame scanner: a falling line opens a frame; bit k is read at start + half + k*c.
  task automatic build_expected(input int which, input int n);
    int c, h, p, t;
    logic [7:0] b;
    logic v, fe, ov, nfe, nov;
    logic [7:0] d;
    c = (which == 1) ? 1 : 4;
    h = (c - 1) / 2;
    for (int i = 0; i < MAXN; i++) begin ev_kind[i] = 0; ev_byte[i] = 8'h00; end
    p = 0;
    while (p < n) begin
      if (lv(which, p) == 1'b1) begin
        p++;
      end else if (h > 0 && (p + h >= n)) begin
        break;
      end else if (h > 0 && lv(which, p + h) == 1'b1) begin
        p = p + h + 1;
      end else begin
        t = p + h + 9*c;
        if (t >= n) break;
        b = 8'h00;
        for (int k = 1; k <= 8; k++) b = {b[6:0], lv(which, p + h + k*c)};
        ev_kind[t] = lv(which, t) ? 1 : 2;
        ev_byte[t] = b;
        p = t + 1;
      end
    end
    v = 1'b0; d = 8'h00; fe = 1'b0; ov = 1'b0;
    for (int k = 0; k < n; k++) begin
      ex[k] = {v, d, fe, ov};
      nfe = (ev_kind[k] == 2);
      nov = 1'b0;
      if (ev_kind[k] == 1) begin
        if (!v || rv(which, k)) begin d = ev_byte[k]; v = 1'b1; end
        else nov = 1'b1;
      end else if (v && rv(which, k)) begin
        v = 1'b0;
      end
      fe = nfe; ov = nov;
    end
  endtask

  task automatic gen_random(input int which, input int n);
    int c, h, p, r, len;
    c = (which == 1) ? 1 : 4;
    h = (c - 1) / 2;
    p = 0;
    while (p + 10*c + 6 < n) begin
      p = p + $urandom_range(0, 3);
      r = $urandom_range(0, 9);
      if (r <= 6) begin
        put_frame(which, p, 8'($urandom), ($urandom_range(0, 5) != 0), 1'b0);
        p = p + 10*c;
      end else if (r <= 8) begin
        len = $urandom_range(1, (h > 0) ? h : 1);
        for (int i = 0; i < len; i++) set_line(which, p + i, 1'b0);
        p = p + len + 1;
      end else begin
        for (int i = 0; i < 5; i++) set_line(which, p + i, 1'($urandom));
        p = p + 5;
      end
    end
    for (int k = 0; k < n; k++) begin
      if (which == 1) rdya1[k] = ($urandom_range(0, 3) != 0);
      else            rdya4[k] = ($urandom_range(0, 3) != 0);
    end
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic [7:0] b;
    logic       stop;
    logic       exp_v;
    logic [7:0] exp_d;
    logic       exp_fe;
  } vec_t;

  vec_t tbl[6];

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    logic any;
    rst = 1'b1; rx1 = 1'b1; rx4 = 1'b1; rdy1 = 1'b1; rdy4 = 1'b1;

    tbl[0] = '{8'hA5, 1'b1, 1'b1, 8'hA5, 1'b0};
    tbl[1] = '{8'h00, 1'b1, 1'b1, 8'h00, 1'b0};
    tbl[2] = '{8'hFF, 1'b1, 1'b1, 8'hFF, 1'b0};
    tbl[3] = '{8'h5A, 1'b0, 1'b0, 8'h00, 1'b1};
    tbl[4] = '{8'h80, 1'b1, 1'b1, 8'h80, 1'b0};
    tbl[5] = '{8'h01, 1'b1, 1'b1, 8'h01, 1'b0};

    // Single frames at one clock per bit: result visible in cycle 10 only.
    foreach (tbl[i]) begin
      do_reset();
      clear_seq();
      put_frame(1, 0, tbl[i].b, tbl[i].stop, 1'b0);
      run_seq(14);
      chk("tbl_v9",   9,  32'(ob1[9].v),   32'd0);
      chk("tbl_v10",  10, 32'(ob1[10].v),  32'(tbl[i].exp_v));
      chk("tbl_d10",  10, 32'(ob1[10].d),  32'(tbl[i].exp_d));
      chk("tbl_fe10", 10, 32'(ob1[10].fe), 32'(tbl[i].exp_fe));
      chk("tbl_v11",  11, 32'(ob1[11].v),  32'd0);
      chk("tbl_fe11", 11, 32'(ob1[11].fe), 32'd0);
      any = 1'b0;
      for (int k = 0; k < 14; k++) any |= ob1[k].ov;
      chk("tbl_no_ovr", i, 32'(any), 32'd0);
    end

    // Back-to-back frames with a start bit right after the stop bit.
    do_reset();
    clear_seq();
    put_frame(1, 0, 8'h00, 1'b1, 1'b0);
    put_frame(1, 10, 8'hFF, 1'b1, 1'b0);
    run_seq(24);
    chk("b2b_v10", 10, 32'(ob1[10].v), 32'd1);
    chk("b2b_d10", 10, 32'(ob1[10].d), 32'h00);
    chk("b2b_v11", 11, 32'(ob1[11].v), 32'd0);
    chk("b2b_v20", 20, 32'(ob1[20].v), 32'd1);
    chk("b2b_d20", 20, 32'(ob1[20].d), 32'hFF);
    chk("b2b_v21", 21, 32'(ob1[21].v), 32'd0);

    // Framing error, then a clean frame.
    do_reset();
    clear_seq();
    put_frame(1, 0, 8'h5A, 1'b0, 1'b0);
    put_frame(1, 12, 8'h12, 1'b1, 1'b0);
    run_seq(26);
    chk("ferr_fe10", 10, 32'(ob1[10].fe), 32'd1);
    chk("ferr_v10",  10, 32'(ob1[10].v),  32'd0);
    chk("ferr_fe11", 11, 32'(ob1[11].fe), 32'd0);
    chk("ferr_v22",  22, 32'(ob1[22].v),  32'd1);
    chk("ferr_d22",  22, 32'(ob1[22].d),  32'h12);

    // Overrun while the consumer stalls, then a one-cycle accept.
    do_reset();
    clear_seq();
    for (int k = 0; k < 40; k++) rdya1[k] = 1'b0;
    rdya1[22] = 1'b1;
    put_frame(1, 0, 8'h11, 1'b1, 1'b0);
    put_frame(1, 10, 8'h22, 1'b1, 1'b0);
    run_seq(26);
    chk("ovr_v10",  10, 32'(ob1[10].v),  32'd1);
    chk("ovr_d10",  10, 32'(ob1[10].d),  32'h11);
    chk("ovr_ov19", 19, 32'(ob1[19].ov), 32'd0);
    chk("ovr_ov20", 20, 32'(ob1[20].ov), 32'd1);
    chk("ovr_d20",  20, 32'(ob1[20].d),  32'h11);
    chk("ovr_v20",  20, 32'(ob1[20].v),  32'd1);
    chk("ovr_ov21", 21, 32'(ob1[21].ov), 32'd0);
    chk("ovr_v22",  22, 32'(ob1[22].v),  32'd1);
    chk("ovr_v23",  23, 32'(ob1[23].v),  32'd0);
    chk("ovr_fe20", 20, 32'(ob1[20].fe), 32'd0);

    // Four clocks per bit: false start, then a frame readable only at offset 1 of each bit.
    do_reset();
    clear_seq();
    line4[0] = 1'b0;
    put_frame(4, 8, 8'h3C, 1'b1, 1'b1);
    run_seq(50);
    chk("fs_st1", 1, 32'(sob4[1]), 32'(START));
    chk("fs_st2", 2, 32'(sob4[2]), 32'(IDLE));
    any = 1'b0;
    for (int k = 0; k < 46; k++) any |= (ob4[k].v | ob4[k].fe | ob4[k].ov);
    chk("fs_quiet", 45, 32'(any), 32'd0);
    chk("c4_v46", 46, 32'(ob4[46].v), 32'd1);
    chk("c4_d46", 46, 32'(ob4[46].d), 32'h3C);

    // Reset in the middle of a frame while a byte is held.
    do_reset();
    clear_seq();
    for (int k = 0; k < 25; k++) rdya1[k] = 1'b0;
    put_frame(1, 0, 8'hA5, 1'b1, 1'b0);
    put_frame(1, 12, 8'h7E, 1'b1, 1'b0);
    rsta[17] = 1'b1;
    for (int k = 18; k < 25; k++) line1[k] = 1'b1;
    put_frame(1, 25, 8'hC3, 1'b1, 1'b0);
    run_seq(40);
    chk("rst_v17",  17, 32'(ob1[17].v), 32'd1);
    chk("rst_d17",  17, 32'(ob1[17].d), 32'hA5);
    chk("rst_v18",  18, 32'(ob1[18].v), 32'd0);
    chk("rst_d18",  18, 32'(ob1[18].d), 32'h00);
    chk("rst_st18", 18, 32'(sob1[18]),  32'(IDLE));
    any = 1'b0;
    for (int k = 0; k < 40; k++) any |= (ob1[k].fe | ob1[k].ov);
    chk("rst_quiet", 39, 32'(any), 32'd0);
    chk("rst_v35",  35, 32'(ob1[35].v), 32'd1);
    chk("rst_d35",  35, 32'(ob1[35].d), 32'hC3);

    // Random line traffic on both receivers against the frame-level model.
    do_reset();
    clear_seq();
    gen_random(1, 1500);
    gen_random(4, 1500);
    run_seq(1500);
    build_expected(1, 1500);
    for (int k = 0; k < 1500; k++) chk("rand_c1", k, 32'(ob1[k]), 32'(ex[k]));
    build_expected(4, 1500);
    for (int k = 0; k < 1500; k++) chk("rand_c4", k, 32'(ob4[k]), 32'(ex[k]));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
